pool1_maxpool: RTL and testbench

- 2x2, stride-2 max-pooling stage that consumes the conv1 output stream: 6 channels x 32-bit, 24x24 valid samples per frame.
- Emits a 12x12, 6-channel pooled stream to the next layer.
- Sits directly downstream of conv1 and accepts its sparse valid pattern (gaps between rows and frames).
- Stream-through block: no backpressure, at most one input sample per cycle.

---
 rtl/pool1_maxpool_pkg.sv | 24 ++
 rtl/pool1_maxpool_if.sv | 40 ++++
 rtl/pool1_maxpool_rowbuf.sv | 40 ++++
 rtl/pool1_maxpool.sv | 129 ++++++++++++
 tb/tb_pool1_maxpool.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pool1_maxpool_pkg.sv
// -----------------------------------------------------------------------------
// pool1_maxpool_pkg
// Shared CNN dimensions for the pool1 stage (conv1 output geometry) and a small
// helper used to size buffer addresses.
// No ports (package).
// -----------------------------------------------------------------------------
package pool1_maxpool_pkg;

    localparam int POOL1_IN_W      = 24;
    localparam int POOL1_IN_H      = 24;
    localparam int POOL1_OUT_W     = POOL1_IN_W / 2;
    localparam int POOL1_OUT_H     = POOL1_IN_H / 2;
    localparam int POOL1_CH        = 6;
    localparam int POOL1_DW        = 32;
    localparam int CNN_CONV1_OUT_W = POOL1_CH * POOL1_DW;
    localparam int CNN_POOL1_OUT_W = POOL1_CH * POOL1_DW;

    // Address width for a buffer of 'depth' entries; never below one bit so a
    // single-entry buffer still has a legal address port.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pool1_maxpool_if.sv
// -----------------------------------------------------------------------------
// pool1_maxpool_if
// Stream bundle between conv1 and the pool1 stage.
//   pool_data_in        : CH*DW packed channels, channel k at [k*DW +: DW]
//   pool_data_in_valid  : one raster-order sample per asserted cycle
//   pool_data_out       : pooled channels, same packing
//   pool_data_out_valid : one-cycle strobe per pooled sample
//   pool_frame_done     : strobe coincident with the last pooled sample
// Modports: master = stream producer / result consumer, slave = pooling block.
// -----------------------------------------------------------------------------
interface pool1_maxpool_if
    import pool1_maxpool_pkg::*;
#(
    parameter int CH = POOL1_CH,
    parameter int DW = POOL1_DW
) ();

    logic [CH*DW-1:0] pool_data_in;
    logic             pool_data_in_valid;
    logic [CH*DW-1:0] pool_data_out;
    logic             pool_data_out_valid;
    logic             pool_frame_done;

    modport master (
        output pool_data_in,
        output pool_data_in_valid,
        input  pool_data_out,
        input  pool_data_out_valid,
        input  pool_frame_done
    );

    modport slave (
        input  pool_data_in,
        input  pool_data_in_valid,
        output pool_data_out,
        output pool_data_out_valid,
        output pool_frame_done
    );

endinterface

// File: rtl/pool1_maxpool_rowbuf.sv
// -----------------------------------------------------------------------------
// pool1_rowbuf
// Register-based line buffer holding the horizontal pair maxima of the even
// input row until the odd row arrives.
//   clk       : clock, rising edge
//   wr_en_i   : write strobe
//   wr_addr_i : write index (pooled column)
//   wr_data_i : CH*DW pair maxima
//   rd_addr_i : read index (pooled column)
//   rd_data_o : combinational read data
// -----------------------------------------------------------------------------
module pool1_rowbuf
    import pool1_maxpool_pkg::*;
#(
    parameter  int DEPTH = POOL1_IN_W / 2,
    parameter  int WIDTH = CNN_CONV1_OUT_W,
    localparam int AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the storage array has no reset on purpose: every entry is written
    // by the even row before the odd row of the same frame reads it, so a
    // reset would only cost a wide clear network for no functional benefit.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pool1_maxpool.sv
// -----------------------------------------------------------------------------
// pool1_maxpool
// 2x2 stride-2 max pooling over a raster stream of CH unsigned DW-bit channels.
// Even columns are parked in a hold register, odd columns form a horizontal
// pair max; even rows store the pair max in the row buffer, odd rows combine it
// with the stored value and register the pooled result (1-cycle latency).
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   pool : stream bundle (slave side), see pool1_maxpool_if
// -----------------------------------------------------------------------------
module pool1_maxpool
    import pool1_maxpool_pkg::*;
#(
    parameter int IN_W = POOL1_IN_W,
    parameter int IN_H = POOL1_IN_H,
    parameter int CH   = POOL1_CH,
    parameter int DW   = POOL1_DW
) (
    input  logic              clk,
    input  logic              rst,
    pool1_maxpool_if.slave    pool
);

    localparam int CW = $clog2(IN_W);
    localparam int RW = $clog2(IN_H);
    localparam int AW = addr_width(IN_W / 2);
    localparam int BW = CH * DW;

    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic [BW-1:0] hold_q, hold_d;
    logic [BW-1:0] out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic          frame_done_q, frame_done_d;

    logic [BW-1:0] pair_w;
    logic [BW-1:0] result_w;
    logic [BW-1:0] rd_data_w;
    logic [AW-1:0] buf_addr_w;
    logic          buf_we_w;
    logic          col_last_w;
    logic          row_last_w;

    assign col_last_w = (col_cnt_q == CW'(IN_W - 1));
    assign row_last_w = (row_cnt_q == RW'(IN_H - 1));
    assign buf_addr_w = AW'(col_cnt_q >> 1);
    assign buf_we_w   = pool.pool_data_in_valid & col_cnt_q[0] & ~row_cnt_q[0];

    // Per-channel unsigned compare; ties fall through to the same value.
    for (genvar k = 0; k < CH; k++) begin : g_max
        logic [DW-1:0] smp;
        logic [DW-1:0] hld;
        logic [DW-1:0] stored;
        logic [DW-1:0] pair;

        assign smp    = pool.pool_data_in[k*DW +: DW];
        assign hld    = hold_q[k*DW +: DW];
        assign stored = rd_data_w[k*DW +: DW];
        assign pair   = (smp > hld) ? smp : hld;

        assign pair_w[k*DW +: DW]   = pair;
        assign result_w[k*DW +: DW] = (stored > pair) ? stored : pair;
    end

    pool1_rowbuf #(
        .DEPTH (IN_W / 2),
        .WIDTH (BW)
    ) u_rowbuf (
        .clk       (clk),
        .wr_en_i   (buf_we_w),
        .wr_addr_i (buf_addr_w),
        .wr_data_i (pair_w),
        .rd_addr_i (buf_addr_w),
        .rd_data_o (rd_data_w)
    );

    // NOTE: every variable gets its hold/default value first so no path
    // through this block leaves one unassigned, which would infer a latch.
    always_comb begin
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        hold_d       = hold_q;
        out_d        = out_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        if (pool.pool_data_in_valid) begin
            if (col_last_w) begin
                col_cnt_d = '0;
                row_cnt_d = row_last_w ? '0 : row_cnt_q + 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end

            if (!col_cnt_q[0]) begin
                hold_d = pool.pool_data_in;
            end else if (row_cnt_q[0]) begin
                out_d        = result_w;
                out_valid_d  = 1'b1;
                frame_done_d = col_last_w & row_last_w;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            hold_q       <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            hold_q       <= hold_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pool.pool_data_out       = out_q;
    assign pool.pool_data_out_valid = out_valid_q;
    assign pool.pool_frame_done     = frame_done_q;

endmodule

// File: tb/tb_pool1_maxpool.sv
// -----------------------------------------------------------------------------
// tb_pool1_maxpool
// Self-checking bench for pool1_maxpool. The bench keeps the full input image,
// computes each 2x2 window maximum directly from it when the bottom-right
// sample is driven, and queues {value, frame_done, due cycle}. A negedge
// monitor pops and compares every output strobe.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pool1_maxpool;
    import pool1_maxpool_pkg::*;

    localparam int W  = POOL1_IN_W;
    localparam int H  = POOL1_IN_H;
    localparam int CH = POOL1_CH;
    localparam int DW = POOL1_DW;
    localparam int OW = W / 2;
    localparam int OH = H / 2;
    localparam int NV = 4;

    typedef logic [CH*DW-1:0] bus_t;

    typedef struct {
        bus_t   data;
        logic   done;
        longint due;
    } exp_t;

    // One table record: a 2x2 window per channel (quadrants TL,TR,BL,BR) and
    // the pooled value every channel must produce.
    typedef struct packed {
        logic [CH-1:0][3:0][DW-1:0] win;
        logic [DW-1:0]              exp;
    } vec_t;

    logic clk;
    logic rst;
    pool1_maxpool_if #(.CH(CH), .DW(DW)) bus ();

    pool1_maxpool #(.IN_W(W), .IN_H(H), .CH(CH), .DW(DW)) dut (
        .clk  (clk),
        .rst  (rst),
        .pool (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     strobes = 0;
    int     dones   = 0;
    bit     mon_en  = 1'b0;
    bus_t   last_out = '0;
    exp_t   sb [$];
    bus_t   log_q [$];

    logic [DW-1:0] img [H][W][CH];
    bit            ovr_en  [OH][OW];
    bus_t          ovr_val [OH][OW];
    vec_t          tbl [NV];

    task automatic check(input string name, input bus_t act, input bus_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor / scoreboard consumer.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_out = '0;
        end else if (mon_en) begin
            if (bus.pool_data_out_valid) begin
                strobes++;
                if (bus.pool_frame_done) dones++;
                log_q.push_back(bus.pool_data_out);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got %h expected no output", bus.pool_data_out);
                end else begin
                    e = sb.pop_front();
                    check("pool_data", bus.pool_data_out, e.data);
                    check("frame_done", bus_t'(bus.pool_frame_done), bus_t'(e.done));
                    check("latency_cycle", bus_t'(cyc), bus_t'(e.due));
                end
                last_out = bus.pool_data_out;
            end else begin
                check("done_without_valid", bus_t'(bus.pool_frame_done), '0);
                check("idle_hold", bus.pool_data_out, last_out);
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void fill_ramp(input bit rev);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                for (int k = 0; k < CH; k++)
                    img[r][c][k] = rev ? DW'(W*H - 1 - (r*W + c)) : DW'(r*W + c);
    endfunction

    function automatic void fill_zero();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                for (int k = 0; k < CH; k++)
                    img[r][c][k] = '0;
    endfunction

    // Window maximum straight from the stored image (or a table override).
    function automatic void push_exp(input int i, input int j);
        exp_t          e;
        logic [DW-1:0] m;
        for (int k = 0; k < CH; k++) begin
            m = img[2*i][2*j][k];
            if (img[2*i][2*j+1][k]   > m) m = img[2*i][2*j+1][k];
            if (img[2*i+1][2*j][k]   > m) m = img[2*i+1][2*j][k];
            if (img[2*i+1][2*j+1][k] > m) m = img[2*i+1][2*j+1][k];
            e.data[k*DW +: DW] = m;
        end
        if (ovr_en[i][j]) e.data = ovr_val[i][j];
        e.done = (i == OH - 1) && (j == OW - 1);
        e.due  = cyc + 1;
        sb.push_back(e);
    endfunction

    task automatic put(input int r, input int c);
        bus_t d;
        for (int k = 0; k < CH; k++) d[k*DW +: DW] = img[r][c][k];
        bus.pool_data_in       = d;
        bus.pool_data_in_valid = 1'b1;
        if ((r % 2 == 1) && (c % 2 == 1)) push_exp(r / 2, c / 2);
        @(posedge clk); #1;
        bus.pool_data_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.pool_data_in       = {CH{$urandom()}};
            bus.pool_data_in_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // gaps=1 mimics conv1: 4 idle cycles after each row plus random holes.
    task automatic send_frame(input bit gaps);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps && ($urandom_range(0, 3) == 0)) idle(1);
                put(r, c);
            end
            if (gaps) idle(4);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        idle(2);
        check("scoreboard_drained", bus_t'(sb.size()), '0);
    endtask

    task automatic clear_stats();
        strobes = 0;
        dones   = 0;
        log_q.delete();
    endtask

    initial begin
        logic [DW-1:0] bases [NV][4];
        logic [DW-1:0] exps  [NV];

        // Table: {5,9,3,7} with the 9 rotated through the quadrants per
        // channel; a large unsigned value; a value with the top bit set
        // against its signed-positive neighbour; an all-equal tie.
        bases[0][0] = 32'd5;          bases[0][1] = 32'd9;
        bases[0][2] = 32'd3;          bases[0][3] = 32'd7;          exps[0] = 32'd9;
        bases[1][0] = 32'hFFFF_FFF0;  bases[1][1] = 32'd7;
        bases[1][2] = 32'd0;          bases[1][3] = 32'd1;          exps[1] = 32'hFFFF_FFF0;
        bases[2][0] = 32'h8000_0000;  bases[2][1] = 32'h7FFF_FFFF;
        bases[2][2] = 32'd1;          bases[2][3] = 32'd2;          exps[2] = 32'h8000_0000;
        bases[3][0] = 32'd4;          bases[3][1] = 32'd4;
        bases[3][2] = 32'd4;          bases[3][3] = 32'd4;          exps[3] = 32'd4;
        for (int v = 0; v < NV; v++) begin
            for (int k = 0; k < CH; k++)
                for (int q = 0; q < 4; q++)
                    tbl[v].win[k][(q + k) % 4] = bases[v][q];
            tbl[v].exp = exps[v];
        end
        for (int i = 0; i < OH; i++)
            for (int j = 0; j < OW; j++) begin
                ovr_en[i][j]  = 1'b0;
                ovr_val[i][j] = '0;
            end

        // Reset with random activity on the inputs.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.pool_data_in       = {CH{$urandom()}};
            bus.pool_data_in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        rst                    = 1'b0;
        bus.pool_data_in_valid = 1'b0;
        check("reset_data_out", bus.pool_data_out, '0);
        check("reset_out_valid", bus_t'(bus.pool_data_out_valid), '0);
        check("reset_frame_done", bus_t'(bus.pool_frame_done), '0);
        mon_en = 1'b1;

        // Ramp, continuous valid.
        clear_stats();
        fill_ramp(1'b0);
        send_frame(1'b0);
        drain();
        check("ramp_strobes", bus_t'(strobes), bus_t'(OW*OH));
        check("ramp_frame_done_count", bus_t'(dones), 1);
        if (log_q.size() == OW*OH) begin
            check("ramp_first_out", log_q[0], {CH{32'd25}});
            check("ramp_last_out", log_q[OW*OH-1], {CH{32'd575}});
        end

        // Ramp with the conv1-style sparse valid pattern.
        clear_stats();
        send_frame(1'b1);
        drain();
        check("gapped_strobes", bus_t'(strobes), bus_t'(OW*OH));
        check("gapped_frame_done_count", bus_t'(dones), 1);

        // Table-driven windows placed on the block diagonal of a zero frame.
        clear_stats();
        fill_zero();
        for (int v = 0; v < NV; v++) begin
            for (int k = 0; k < CH; k++)
                for (int q = 0; q < 4; q++)
                    img[2*v + q/2][2*v + q%2][k] = tbl[v].win[k][q];
            ovr_en[v][v]  = 1'b1;
            ovr_val[v][v] = {CH{tbl[v].exp}};
        end
        send_frame(1'b0);
        drain();
        for (int v = 0; v < NV; v++) ovr_en[v][v] = 1'b0;
        check("table_strobes", bus_t'(strobes), bus_t'(OW*OH));

        // Reset in the middle of a frame, at input (row 7, col 10).
        fill_ramp(1'b0);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < W; c++)
                if (r < 7 || c < 10) put(r, c);
        rst                    = 1'b1;
        bus.pool_data_in       = {CH{32'(7*W + 10)}};
        bus.pool_data_in_valid = 1'b1;
        @(posedge clk); #1;
        rst                    = 1'b0;
        bus.pool_data_in_valid = 1'b0;
        sb.delete();
        check("midreset_data_out", bus.pool_data_out, '0);
        check("midreset_out_valid", bus_t'(bus.pool_data_out_valid), '0);
        clear_stats();
        send_frame(1'b0);
        drain();
        check("midreset_strobes", bus_t'(strobes), bus_t'(OW*OH));
        check("midreset_frame_done_count", bus_t'(dones), 1);

        // Back-to-back: ramp then descending ramp, no gap between frames.
        clear_stats();
        fill_ramp(1'b0);
        send_frame(1'b0);
        fill_ramp(1'b1);
        send_frame(1'b0);
        drain();
        check("b2b_strobes", bus_t'(strobes), bus_t'(2*OW*OH));
        check("b2b_frame_done_count", bus_t'(dones), 2);
        // In a descending ramp the top-left sample dominates each window.
        if (log_q.size() == 2*OW*OH)
            check("b2b_second_first_out", log_q[OW*OH], {CH{32'd575}});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
